secded_codec: RTL and testbench



---
 rtl/secded_codec.sv | 143 ++++++++++++++
 tb/tb_secded_codec.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/secded_codec.sv
// Extended-Hamming (SECDED) encoder, error injector and decoder with a two-stage
// valid/ready pipeline and saturating corrected/uncorrectable event counters.
module secded_codec #(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int P      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] err_inj,
  input  logic              correct_en,
  input  logic              cnt_clr,
  output logic [CODE_W-1:0] code_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_single,
  output logic              out_double,
  output logic [P-1:0]      out_err_pos,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [P-1:0]      MAX_POS = P'(CODE_W - 1);
  localparam logic [CODE_W-1:0] ONE     = CODE_W'(1);

  // Data bits fill the non-power-of-two Hamming positions in ascending order.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic [P-1:0]      syn;
    int                k;
    c   = '0;
    syn = '0;
    k   = 0;
    for (int i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int i = 1; i < CODE_W; i++) begin
      if (c[i]) syn ^= i[P-1:0];
    end
    for (int j = 0; j < P; j++) c[1 << j] = syn[j];
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int i = 3; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never drops and its payload never changes until that transfer happens.
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic              s2_adv;
  logic              s1_adv;

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign code_word = s1_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_code <= encode(in_data) ^ err_inj;
    end
  end

  logic [P-1:0]      dec_syn;
  logic              dec_par;
  logic              dec_single;
  logic              dec_double;
  logic [CODE_W-1:0] dec_fixed;

  always_comb begin
    dec_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (s1_code[i]) dec_syn ^= i[P-1:0];
    end
    dec_par    = ^s1_code;
    dec_single = dec_par && (dec_syn <= MAX_POS);
    // A syndrome beyond the last position with odd parity cannot be a single flip.
    dec_double = (dec_par && (dec_syn > MAX_POS)) || (!dec_par && (dec_syn != '0));
    dec_fixed  = s1_code;
    if (dec_single && correct_en) dec_fixed = s1_code ^ (ONE << dec_syn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_single   <= 1'b0;
      out_double   <= 1'b0;
      out_err_pos  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= extract(dec_fixed);
        out_syndrome <= dec_syn;
        out_single   <= dec_single;
        out_double   <= dec_double;
        out_err_pos  <= dec_single ? dec_syn : '0;
      end
    end
  end

  // A clear in the same cycle as an accepted event drops that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_single && (corr_cnt != '1))   corr_cnt   <= corr_cnt + 1'b1;
      if (out_double && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_codec.sv
// Directed bench for secded_codec (DATA_W=8, CNT_W=2): encoding, correction,
// double detection, counter saturation/clear, back-to-back stalls and mid-stream reset.
module tb_secded_codec;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int P      = 4;
  localparam int CODE_W = 13;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] err_inj;
  logic              correct_en;
  logic              cnt_clr;
  logic [CODE_W-1:0] code_word;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syndrome;
  logic              out_single;
  logic              out_double;
  logic [P-1:0]      out_err_pos;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  secded_codec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .err_inj(err_inj), .correct_en(correct_en), .cnt_clr(cnt_clr),
    .code_word(code_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_single(out_single),
    .out_double(out_double), .out_err_pos(out_err_pos),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One word through an idle pipeline; returns with its result on the outputs.
  task automatic run_word(input logic [7:0] d, input logic [12:0] inj, input logic cen);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; err_inj = inj; correct_en = cen;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; err_inj = '0;
    correct_en = 1'b1; cnt_clr = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (code_word !== 13'h0) begin errors++; $display("FAIL reset_code_word: got %h exp 0", code_word); end
    checks++; if ({out_data, out_syndrome, out_single, out_double, out_err_pos} !== 18'h0) begin
      errors++; $display("FAIL reset_outs: got data %h syn %h s %b d %b pos %h exp all 0", out_data, out_syndrome, out_single, out_double, out_err_pos); end
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'h0) begin errors++; $display("FAIL reset_cnts: got %h/%h exp 0/0", corr_cnt, uncorr_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean;
    run_word(8'hA5, 13'h0000, 1'b1);
    checks++; if (code_word !== 13'h144E) begin errors++; $display("FAIL clean_code_word: got %h exp 144e", code_word); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL clean_data: got %h exp a5", out_data); end
    checks++; if ({out_syndrome, out_single, out_double} !== 6'b0) begin
      errors++; $display("FAIL clean_flags: got syn %h s %b d %b exp 0 0 0", out_syndrome, out_single, out_double); end
    step();
    checks++; if (corr_cnt !== 2'd0) begin errors++; $display("FAIL clean_corr_cnt: got %0d exp 0", corr_cnt); end
  endtask

  task automatic test_single;
    run_word(8'hA5, 13'h0040, 1'b1);
    checks++; if (code_word !== 13'h140E) begin errors++; $display("FAIL single_code_word: got %h exp 140e", code_word); end
    checks++; if ({out_single, out_double, out_err_pos, out_syndrome} !== {1'b1, 1'b0, 4'd6, 4'd6}) begin
      errors++; $display("FAIL single_flags: got s %b d %b pos %0d syn %0d exp 1 0 6 6", out_single, out_double, out_err_pos, out_syndrome); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", out_data); end
    step();
    checks++; if (corr_cnt !== 2'd1) begin errors++; $display("FAIL single_corr_cnt: got %0d exp 1", corr_cnt); end
    // bit 6 holds d2, so report-only mode shows d2 flipped
    run_word(8'hA5, 13'h0040, 1'b0);
    checks++; if ({out_single, out_err_pos} !== {1'b1, 4'd6}) begin
      errors++; $display("FAIL nocorr_flags: got s %b pos %0d exp 1 6", out_single, out_err_pos); end
    checks++; if (out_data !== 8'hA1) begin errors++; $display("FAIL nocorr_data: got %h exp a1", out_data); end
    step();
    checks++; if (corr_cnt !== 2'd2) begin errors++; $display("FAIL nocorr_corr_cnt: got %0d exp 2", corr_cnt); end
    run_word(8'hA5, 13'h0001, 1'b1);
    checks++; if ({out_single, out_double, out_err_pos, out_syndrome} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
      errors++; $display("FAIL parity_flags: got s %b d %b pos %0d syn %0d exp 1 0 0 0", out_single, out_double, out_err_pos, out_syndrome); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL parity_data: got %h exp a5", out_data); end
    step();
    checks++; if (corr_cnt !== 2'd3) begin errors++; $display("FAIL parity_corr_cnt: got %0d exp 3", corr_cnt); end
  endtask

  task automatic test_double;
    run_word(8'hA5, 13'h0408, 1'b1);
    checks++; if ({out_single, out_double, out_err_pos, out_syndrome} !== {1'b0, 1'b1, 4'd0, 4'd9}) begin
      errors++; $display("FAIL double_flags: got s %b d %b pos %0d syn %0d exp 0 1 0 9", out_single, out_double, out_err_pos, out_syndrome); end
    checks++; if (out_data !== 8'h84) begin errors++; $display("FAIL double_data: got %h exp 84", out_data); end
    step();
    checks++; if ({corr_cnt, uncorr_cnt} !== {2'd3, 2'd1}) begin errors++; $display("FAIL double_cnts: got %0d/%0d exp 3/1", corr_cnt, uncorr_cnt); end
    run_word(8'hA5, 13'h1006, 1'b1);
    checks++; if ({out_single, out_double, out_err_pos, out_syndrome} !== {1'b0, 1'b1, 4'd0, 4'd15}) begin
      errors++; $display("FAIL oob_flags: got s %b d %b pos %0d syn %0d exp 0 1 0 15", out_single, out_double, out_err_pos, out_syndrome); end
    checks++; if (out_data !== 8'h25) begin errors++; $display("FAIL oob_data: got %h exp 25", out_data); end
    step();
    checks++; if (uncorr_cnt !== 2'd2) begin errors++; $display("FAIL oob_uncorr_cnt: got %0d exp 2", uncorr_cnt); end
  endtask

  task automatic test_saturation;
    @(negedge clk); cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'h0) begin errors++; $display("FAIL clr_cnts: got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    for (int i = 0; i < 5; i++) begin
      run_word(8'h5A, 13'h0010, 1'b1);
      step();
      checks++; if (corr_cnt !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++; $display("FAIL sat_corr_cnt[%0d]: got %0d exp %0d", i, corr_cnt, (i + 1 > 3) ? 3 : i + 1); end
    end
  endtask

  task automatic test_clr_collision;
    run_word(8'h3C, 13'h0100, 1'b1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (corr_cnt !== 2'd0) begin errors++; $display("FAIL clr_collision: got %0d exp 0", corr_cnt); end
    run_word(8'h3C, 13'h0100, 1'b1);
    step();
    checks++; if (corr_cnt !== 2'd1) begin errors++; $display("FAIL clr_after: got %0d exp 1", corr_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words[20];
    logic [8:0] exp;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       fire_in;
    logic       fire_out;
    int sent;
    int recv;
    int cyc;
    for (int i = 0; i < 20; i++) words[i] = 8'(i * 37 + 11);
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    exp_q.delete();
    while (recv < 20 && cyc < 300) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      if (sent < 20) begin
        in_valid = 1'b1; in_data = words[sent]; correct_en = 1'b1;
        err_inj = (sent % 4 == 0) ? 13'h0 : (13'd1 << (sent % 13));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL stall_hold: got v %b data %h exp 1 %h", out_valid, out_data, prev_data); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got word %h exp none", out_data);
        end else begin
          exp = exp_q.pop_front();
          if ({out_single, out_data} !== exp) begin
            errors++; $display("FAIL b2b_word[%0d]: got s %b data %h exp s %b data %h", recv, out_single, out_data, exp[8], exp[7:0]); end
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (fire_in) begin
        exp_q.push_back({(sent % 4 != 0), words[sent]});
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv !== 20) begin errors++; $display("FAIL b2b_count: got %0d exp 20 (cycle budget)", recv); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    step();
    step();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; err_inj = 13'h0040; correct_en = 1'b1; out_ready = 1'b1;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_single, out_data, out_err_pos, out_syndrome} !== 18'h0) begin
      errors++; $display("FAIL midrst_outs: got v %b s %b data %h pos %0d syn %0d exp all 0", out_valid, out_single, out_data, out_err_pos, out_syndrome); end
    checks++; if (code_word !== 13'h0) begin errors++; $display("FAIL midrst_code_word: got %h exp 0", code_word); end
    checks++; if ({corr_cnt, uncorr_cnt} !== 4'h0) begin errors++; $display("FAIL midrst_cnts: got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b exp 1", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    checks++; if ({out_valid, corr_cnt} !== 3'b0) begin errors++; $display("FAIL midrst_after: got v %b corr %0d exp 0 0", out_valid, corr_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_saturation();
    test_clr_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
